// File: rtl/instruction_fetch_sequencer_pkg.sv
// rtl/instruction_fetch_sequencer_pkg.sv - shared types and constants for the instruction fetch sequencer
//
// Contents:
//   ADDR_W_DEFAULT  default address / program counter width
//   LH_LOW/LH_HIGH  IRLH encodings (low half / high half of the instruction register)
//   fetch_state_t   FSM state encoding
//   is_req_state    true in the two states that have a memory read outstanding
package instruction_fetch_sequencer_pkg;

  localparam int ADDR_W_DEFAULT = 16;

  localparam logic LH_LOW  = 1'b0;
  localparam logic LH_HIGH = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ_LO = 3'd1,
    ST_WR_LO  = 3'd2,
    ST_REQ_HI = 3'd3,
    ST_WR_HI  = 3'd4
  } fetch_state_t;

  function automatic logic is_req_state(input fetch_state_t s);
    return (s == ST_REQ_LO) || (s == ST_REQ_HI);
  endfunction

endpackage

// File: rtl/instruction_pc_counter.sv
// rtl/instruction_pc_counter.sv - loadable, incrementing, wrapping program counter register
//
// Ports:
//   Clock      rising-edge clock
//   Reset      synchronous active-low reset, Count returns to RESET_PC
//   Load       load Count from LoadValue (wins over Increment)
//   LoadValue  value taken on Load
//   Increment  advance Count by one, wrapping modulo 2^ADDR_W
//   Count      current value
module instruction_pc_counter
  import instruction_fetch_sequencer_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEFAULT,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Load,
  input  logic [ADDR_W-1:0] LoadValue,
  input  logic              Increment,
  output logic [ADDR_W-1:0] Count
);

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(1);

  // Plain modular addition: the carry out of the top bit is dropped, so
  // all-ones rolls over to zero with no overflow indication.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      Count <= RESET_PC;
    end else if (Load) begin
      Count <= LoadValue;
    end else if (Increment) begin
      Count <= Count + PC_STEP;
    end
  end

endmodule

// File: rtl/instruction_fetch_sequencer.sv
// rtl/instruction_fetch_sequencer.sv - fetches a 16-bit instruction as two bytes into the instruction register
//
// Ports:
//   Clock        rising-edge clock
//   Reset        synchronous active-low reset
//   Start        begin a fetch (looked at only in IDLE)
//   PCLoad       load PC from PCLoadValue (looked at only in IDLE)
//   PCLoadValue  new PC value
//   MemReady     memory data valid for the outstanding read
//   MemData      memory read byte
//   MemRead      read request, high in REQ_LO / REQ_HI
//   MemAddress   read address, always equal to PC
//   IRData       registered memory byte presented to the instruction register
//   IRWrite      instruction register write strobe
//   IRLH         half select for IRWrite (LH_LOW = IR[7:0], LH_HIGH = IR[15:8])
//   PC           current program counter
//   Busy         high whenever the FSM is not in IDLE
//   Done         one-cycle pulse in the cycle the high byte is written
//
// The low byte is fetched from PC and the high byte from PC+1 (little-endian);
// PC advances once per written byte, so after a fetch it points at the next
// instruction.
module instruction_fetch_sequencer
  import instruction_fetch_sequencer_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEFAULT,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              PCLoad,
  input  logic [ADDR_W-1:0] PCLoadValue,
  input  logic              MemReady,
  input  logic [7:0]        MemData,
  output logic              MemRead,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [7:0]        IRData,
  output logic              IRWrite,
  output logic              IRLH,
  output logic [ADDR_W-1:0] PC,
  output logic              Busy,
  output logic              Done
);

  fetch_state_t state;
  fetch_state_t state_next;

  logic pc_load;
  logic pc_inc;
  logic mem_capture;

  // State register
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // MemReady only means something while a read is outstanding; anywhere else
  // it is ignored so stray pulses cannot corrupt the held byte.
  assign mem_capture = is_req_state(state) && MemReady;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      IRData <= 8'h00;
    end else if (mem_capture) begin
      IRData <= MemData;
    end
  end

  // Next-state and Moore output decode. All strobes come from the state
  // register alone; PCLoad is only forwarded to the counter while idle.
  always_comb begin
    state_next = state;
    MemRead    = 1'b0;
    IRWrite    = 1'b0;
    IRLH       = LH_LOW;
    Busy       = 1'b1;
    Done       = 1'b0;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;

    case (state)
      ST_IDLE: begin
        Busy    = 1'b0;
        pc_load = PCLoad;
        if (Start) begin
          state_next = ST_REQ_LO;
        end
      end

      // Wait states are unbounded: the request stays up until memory answers.
      ST_REQ_LO: begin
        MemRead = 1'b1;
        if (MemReady) begin
          state_next = ST_WR_LO;
        end
      end

      ST_WR_LO: begin
        IRWrite    = 1'b1;
        IRLH       = LH_LOW;
        pc_inc     = 1'b1;
        state_next = ST_REQ_HI;
      end

      ST_REQ_HI: begin
        MemRead = 1'b1;
        if (MemReady) begin
          state_next = ST_WR_HI;
        end
      end

      ST_WR_HI: begin
        IRWrite    = 1'b1;
        IRLH       = LH_HIGH;
        pc_inc     = 1'b1;
        Done       = 1'b1;
        state_next = ST_IDLE;
      end

      default: begin
        Busy       = 1'b0;
        state_next = ST_IDLE;
      end
    endcase
  end

  instruction_pc_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .Clock     (Clock),
    .Reset     (Reset),
    .Load      (pc_load),
    .LoadValue (PCLoadValue),
    .Increment (pc_inc),
    .Count     (PC)
  );

  assign MemAddress = PC;

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// tb/tb_instruction_fetch_sequencer.sv - directed self-checking bench for instruction_fetch_sequencer
module tb_instruction_fetch_sequencer;

  logic        Clock;
  logic        Reset;
  logic        Start;
  logic        PCLoad;
  logic [15:0] PCLoadValue;
  logic        MemReady;
  logic [7:0]  MemData;
  logic        MemRead;
  logic [15:0] MemAddress;
  logic [7:0]  IRData;
  logic        IRWrite;
  logic        IRLH;
  logic [15:0] PC;
  logic        Busy;
  logic        Done;

  int checks = 0;
  int errors = 0;

  instruction_fetch_sequencer #(
    .ADDR_W   (16),
    .RESET_PC (16'h0000)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Start       (Start),
    .PCLoad      (PCLoad),
    .PCLoadValue (PCLoadValue),
    .MemReady    (MemReady),
    .MemData     (MemData),
    .MemRead     (MemRead),
    .MemAddress  (MemAddress),
    .IRData      (IRData),
    .IRWrite     (IRWrite),
    .IRLH        (IRLH),
    .PC          (PC),
    .Busy        (Busy),
    .Done        (Done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // {MemRead, MemAddress, IRData, IRWrite, IRLH, PC, Busy, Done}
  logic [44:0] outs;
  assign outs = {MemRead, MemAddress, IRData, IRWrite, IRLH, PC, Busy, Done};

  typedef struct {
    logic        start;
    logic        pcload;
    logic [15:0] loadval;
    logic        ready;
    logic [7:0]  data;
    logic        e_read;
    logic [15:0] e_addr;
    logic [7:0]  e_ir;
    logic        e_irw;
    logic        e_lh;
    logic [15:0] e_pc;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [44:0] exp;
    int          n;
    int          done_n;
    int          done_cnt;
    logic [15:0] base;

    // Basic fetch: load 0010, bytes 34 then 12; Done in the 4th cycle after Start
    vecs[0]  = '{1'b1, 1'b1, 16'h0010, 1'b1, 8'h34, 1'b1, 16'h0010, 8'h00, 1'b0, 1'b0, 16'h0010, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 8'h34, 1'b0, 16'h0010, 8'h34, 1'b1, 1'b0, 16'h0010, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 8'h12, 1'b1, 16'h0011, 8'h34, 1'b0, 1'b0, 16'h0011, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 8'h12, 1'b0, 16'h0011, 8'h12, 1'b1, 1'b1, 16'h0011, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 8'h12, 1'b0, 16'h0012, 8'h12, 1'b0, 1'b0, 16'h0012, 1'b0, 1'b0};
    // Wrap: FFFF then 0000, final PC 0001
    vecs[5]  = '{1'b1, 1'b1, 16'hFFFF, 1'b1, 8'hAA, 1'b1, 16'hFFFF, 8'h12, 1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 8'hAA, 1'b0, 16'hFFFF, 8'hAA, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 8'hBB, 1'b1, 16'h0000, 8'hAA, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 8'hBB, 1'b0, 16'h0000, 8'hBB, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 8'hBB, 1'b0, 16'h0001, 8'hBB, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0};
    // Load+start 0200, then Start/PCLoad 0500 during REQ_HI are ignored
    vecs[10] = '{1'b1, 1'b1, 16'h0200, 1'b0, 8'h56, 1'b1, 16'h0200, 8'hBB, 1'b0, 1'b0, 16'h0200, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 16'h0000, 1'b1, 8'h56, 1'b0, 16'h0200, 8'h56, 1'b1, 1'b0, 16'h0200, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 16'h0000, 1'b0, 8'h78, 1'b1, 16'h0201, 8'h56, 1'b0, 1'b0, 16'h0201, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 16'h0500, 1'b0, 8'h78, 1'b1, 16'h0201, 8'h56, 1'b0, 1'b0, 16'h0201, 1'b1, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 16'h0500, 1'b1, 8'h78, 1'b0, 16'h0201, 8'h78, 1'b1, 1'b1, 16'h0201, 1'b1, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 16'h0000, 1'b0, 8'h78, 1'b0, 16'h0202, 8'h78, 1'b0, 1'b0, 16'h0202, 1'b0, 1'b0};

    // Reset state, with noisy inputs that must not matter under reset
    Reset       = 1'b0;
    Start       = 1'b1;
    PCLoad      = 1'b1;
    PCLoadValue = 16'h1234;
    MemReady    = 1'b1;
    MemData     = 8'hEE;
    step();
    step();
    check("reset_state", 64'(outs), 64'(45'h0));

    Start    = 1'b0;
    PCLoad   = 1'b0;
    MemReady = 1'b0;
    Reset    = 1'b1;
    step();
    check("idle_after_reset", 64'(outs), 64'(45'h0));

    // Table-driven sequences
    for (int i = 0; i < 16; i++) begin
      Start       = vecs[i].start;
      PCLoad      = vecs[i].pcload;
      PCLoadValue = vecs[i].loadval;
      MemReady    = vecs[i].ready;
      MemData     = vecs[i].data;
      step();
      exp = {vecs[i].e_read, vecs[i].e_addr, vecs[i].e_ir, vecs[i].e_irw,
             vecs[i].e_lh, vecs[i].e_pc, vecs[i].e_busy, vecs[i].e_done};
      check($sformatf("vec%0d", i), 64'(outs), 64'(exp));
    end
    Start  = 1'b0;
    PCLoad = 1'b0;

    // Wait states: 3 low cycles in REQ_LO, 2 in REQ_HI -> Done 9 cycles after Start
    base     = 16'h0202;
    done_n   = -1;
    done_cnt = 0;
    Start    = 1'b1;
    MemReady = 1'b0;
    MemData  = 8'hC3;
    step();
    Start = 1'b0;
    n     = 1;
    while (n < 20) begin
      if (Done) begin
        done_cnt++;
        if (done_n < 0) done_n = n;
      end
      if ((n >= 1 && n <= 4) || (n >= 6 && n <= 8)) begin
        check($sformatf("wait_req_c%0d", n), 64'({MemRead, MemAddress}),
              64'({1'b1, (n <= 4) ? base : base + 16'h0001}));
      end
      if (!Busy) break;
      MemReady = (n == 4) || (n == 8);
      MemData  = (n < 5) ? 8'hC3 : 8'h3C;
      step();
      n++;
    end
    check("wait_bounded", 64'(n < 20), 64'(1));
    check("wait_done_cycle", 64'(done_n), 64'(9));
    check("wait_done_count", 64'(done_cnt), 64'(1));
    check("wait_final", 64'({PC, IRData, Busy}), 64'({16'h0204, 8'h3C, 1'b0}));
    MemReady = 1'b0;

    // Reset in WR_LO aborts the fetch
    Start    = 1'b1;
    MemReady = 1'b1;
    MemData  = 8'h99;
    step();
    Start = 1'b0;
    step();
    check("abort_in_wr_lo", 64'({IRWrite, IRLH, Busy, PC, IRData}),
          64'({1'b1, 1'b0, 1'b1, 16'h0204, 8'h99}));
    Reset = 1'b0;
    step();
    check("abort_reset", 64'(outs), 64'(45'h0));
    Reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("abort_quiet_c%0d", k), 64'({Done, IRWrite, Busy, PC}),
            64'({1'b0, 1'b0, 1'b0, 16'h0000}));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
